// File: rtl/program_loader.sv
// Boot loader: assembles little-endian 32-bit words from a byte stream into instruction memory
// and holds the core in reset until a valid image is loaded. Optional: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byteIn,
   input  logic        byteValid,
   output logic        byteReady,
   output logic        imemWrite,
   output logic [31:0] imemAddress,
   output logic [31:0] imemData,
   output logic        coreReset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] wordCount
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StIdle, StLenLo, StLenHi, StData, StChk, StDone, StError
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StLenLo, StLenHi, StData, StDone, StError
   } state_e;
`endif

   state_e      state_q, state_d;
   logic [15:0] length_q, length_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] buf_q, buf_d;
   logic [31:0] data_q, data_d;
   logic [31:0] addr_q, addr_d;
   logic        write_q, write_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic [15:0] len_next;
   logic        accept;
   logic        ready;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]  chk_q, chk_d;
   localparam state_e StLast = StChk;
`else
   localparam state_e StLast = StDone;
`endif

   assign accept = byteValid && ready;

   always_comb begin
      state_d    = state_q;
      length_d   = length_q;
      byte_idx_d = byte_idx_q;
      buf_d      = buf_q;
      data_d     = data_q;
      addr_d     = addr_q;
      write_d    = 1'b0;
      word_cnt_d = word_cnt_q;
      len_next   = {byteIn, length_q[7:0]};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk_d      = chk_q;
`endif
      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d    = StLenLo;
               word_cnt_d = 16'd0;
               byte_idx_d = 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               chk_d      = 8'd0;
`endif
            end
         end
         StLenLo: begin
            if (accept) begin
               length_d[7:0] = byteIn;
               state_d       = StLenHi;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               chk_d         = chk_q ^ byteIn;
`endif
            end
         end
         StLenHi: begin
            if (accept) begin
               length_d = len_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               chk_d    = chk_q ^ byteIn;
`endif
               if (len_next == 16'd0) begin
                  state_d = StLast;
               end else if (32'(len_next) > MAX_WORDS) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               byte_idx_d = byte_idx_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ byteIn;
`endif
               unique case (byte_idx_q)
                  2'd0: buf_d[7:0]   = byteIn;
                  2'd1: buf_d[15:8]  = byteIn;
                  2'd2: buf_d[23:16] = byteIn;
                  default: begin
                     data_d     = {byteIn, buf_q};
                     addr_d     = ADDR_BASE + {14'd0, word_cnt_q, 2'b00};
                     write_d    = 1'b1;
                     word_cnt_d = word_cnt_q + 16'd1;
                     if (word_cnt_d == length_q) begin
                        state_d = StLast;
                     end
                  end
               endcase
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StChk: begin
            if (accept) begin
               state_d = (byteIn == chk_q) ? StDone : StError;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      unique case (state_q)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         StLenLo, StLenHi, StData, StChk: ready = 1'b1;
`else
         StLenLo, StLenHi, StData: ready = 1'b1;
`endif
         default: ready = 1'b0;
      endcase
   end

   assign byteReady   = ready;
   assign busy        = ready;
   assign done        = (state_q == StDone);
   assign coreReset   = (state_q == StDone);
   assign error       = (state_q == StError);
   assign imemWrite   = write_q;
   assign imemAddress = addr_q;
   assign imemData    = data_q;
   assign wordCount   = word_cnt_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= StIdle;
         length_q   <= 16'd0;
         byte_idx_q <= 2'd0;
         buf_q      <= 24'd0;
         data_q     <= 32'd0;
         addr_q     <= ADDR_BASE;
         write_q    <= 1'b0;
         word_cnt_q <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         chk_q      <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         length_q   <= length_d;
         byte_idx_q <= byte_idx_d;
         buf_q      <= buf_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         word_cnt_q <= word_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; outputs sampled 1 time unit after each edge.
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset, start, byteValid;
   logic [7:0]  byteIn;
   logic        byteReady, imemWrite, coreReset, busy, done, error;
   logic [31:0] imemAddress, imemData;
   logic [15:0] wordCount;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;
   int base     = 0;
   logic [31:0] wa [16];
   logic [31:0] wd [16];

   program_loader #(
      .MAX_WORDS(256),
      .ADDR_BASE(32'h0000_0000)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .byteIn     (byteIn),
      .byteValid  (byteValid),
      .byteReady  (byteReady),
      .imemWrite  (imemWrite),
      .imemAddress(imemAddress),
      .imemData   (imemData),
      .coreReset  (coreReset),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .wordCount  (wordCount)
   );

   always #5 clock = ~clock;

   // Log every cycle in which the write strobe is high.
   always @(posedge clock) begin
      if (imemWrite) begin
         if (wr_cnt < 16) begin
            wa[wr_cnt] <= imemAddress;
            wd[wr_cnt] <= imemData;
         end
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      byteIn    = b;
      byteValid = 1'b1;
      step();
      byteValid = 1'b0;
   endtask

   task automatic send_stall(input logic [7:0] b);
      send(b);
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
      step();
      step();
      check("rst_coreReset", coreReset, 0);
      check("rst_done", done, 0);
      check("rst_byteReady", byteReady, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_wordCount", wordCount, 0);
      check("rst_addr", imemAddress, 32'h0);
      reset = 1'b1;
      step();
      check("idle_byteReady", byteReady, 0);
      pulse_start();
      check("start_byteReady", byteReady, 1);
      check("start_busy", busy, 1);

      // Two-word image, continuous stream
      send(8'h02); send(8'h00);
      check("cont_data_busy", busy, 1);
      send(8'h13); send(8'h05); send(8'h10); send(8'h00);
      check("cont_w0_write", imemWrite, 1);
      check("cont_w0_addr", imemAddress, 32'h0);
      check("cont_w0_data", imemData, 32'h0010_0513);
      check("cont_w0_cnt", wordCount, 1);
      check("cont_byteReady_wr", byteReady, 1);
      send(8'h93);
      check("cont_w0_pulse_end", imemWrite, 0);
      send(8'h05); send(8'h20); send(8'h00);
      check("cont_w1_write", imemWrite, 1);
      check("cont_w1_addr", imemAddress, 32'h4);
      check("cont_w1_data", imemData, 32'h0020_0593);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send(8'hB2);
`endif
      step();
      check("cont_nwrites", wr_cnt, 2);
      check("cont_wa0", wa[0], 32'h0);
      check("cont_wd0", wd[0], 32'h0010_0513);
      check("cont_wa1", wa[1], 32'h4);
      check("cont_wd1", wd[1], 32'h0020_0593);
      check("cont_done", done, 1);
      check("cont_coreReset", coreReset, 1);
      check("cont_wordCount", wordCount, 2);
      check("cont_write_idle", imemWrite, 0);

      // Byte offered while not ready is ignored
      byteIn = 8'hFF; byteValid = 1'b1;
      step();
      byteValid = 1'b0;
      step();
      check("ign_done", done, 1);
      check("ign_wordCount", wordCount, 2);
      check("ign_nwrites", wr_cnt, 2);

      // Same image with stalled handshake
      base = wr_cnt;
      pulse_start();
      check("stall_restart_cnt", wordCount, 0);
      check("stall_restart_coreReset", coreReset, 0);
      check("stall_restart_busy", busy, 1);
      send_stall(8'h02); send_stall(8'h00);
      send_stall(8'h13); send_stall(8'h05); send_stall(8'h10);
      send(8'h00);
      check("stall_w0_write", imemWrite, 1);
      step();
      check("stall_w0_onecycle", imemWrite, 0);
      send_stall(8'h93); send_stall(8'h05); send_stall(8'h20); send_stall(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_stall(8'hB2);
`endif
      step();
      check("stall_nwrites", wr_cnt - base, 2);
      check("stall_wa0", wa[base], 32'h0);
      check("stall_wd0", wd[base], 32'h0010_0513);
      check("stall_wa1", wa[base+1], 32'h4);
      check("stall_wd1", wd[base+1], 32'h0020_0593);
      check("stall_done", done, 1);
      check("stall_wordCount", wordCount, 2);

      // Oversize image (257 words)
      base = wr_cnt;
      pulse_start();
      send(8'h01); send(8'h01);
      check("big_error", error, 1);
      check("big_coreReset", coreReset, 0);
      check("big_busy", busy, 0);
      check("big_byteReady", byteReady, 0);
      step();
      check("big_nwrites", wr_cnt - base, 0);
      pulse_start();
      check("big_restart_error", error, 0);
      check("big_restart_busy", busy, 1);
      check("big_restart_cnt", wordCount, 0);

      // Zero-length image
      send(8'h00); send(8'h00);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send(8'h00);
`endif
      check("zero_done", done, 1);
      check("zero_cnt", wordCount, 0);
      check("zero_nwrites", wr_cnt - base, 0);

      // Reset in the middle of a load
      pulse_start();
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h05); send(8'h10); send(8'h00); send(8'h93); send(8'h05);
      check("mid_cnt", wordCount, 1);
      reset = 1'b0;
      step();
      check("mid_busy", busy, 0);
      check("mid_cnt_rst", wordCount, 0);
      check("mid_write", imemWrite, 0);
      check("mid_byteReady", byteReady, 0);
      check("mid_nwrites", wr_cnt - base, 1);
      check("mid_wa0", wa[base], 32'h0);
      reset = 1'b1;
      step();
      check("mid_idle_done", done, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Checksum pass then fail
      pulse_start();
      send(8'h01); send(8'h00); send(8'h13); send(8'h05); send(8'h10); send(8'h00);
      check("chk_busy", busy, 1);
      check("chk_byteReady", byteReady, 1);
      send(8'h07);
      check("chk_ok_done", done, 1);
      check("chk_ok_coreReset", coreReset, 1);
      pulse_start();
      send(8'h01); send(8'h00); send(8'h13); send(8'h05); send(8'h10); send(8'h00);
      send(8'h08);
      check("chk_bad_error", error, 1);
      check("chk_bad_coreReset", coreReset, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader upstream of the single-cycle datapath.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through its write port.
- Holds the core in reset until a complete, valid image is loaded.

Parameters:
- MAX_WORDS, 256: maximum image length in words; longer images are rejected.
- ADDR_BASE, 32'h0000_0000: byte address of the first word written.

Ports:
- clock, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-low reset; sampled on the rising edge of clock.
- start, input, 1: begin a load; sampled only in IDLE, DONE or ERROR.
- byteIn, input, 8: stream byte.
- byteValid, input, 1: byteIn is valid.
- byteReady, output, 1: loader can accept a byte.
- imemWrite, output, 1: one-cycle instruction-memory write strobe.
- imemAddress, output, 32: byte address of the write (ADDR_BASE + 4*wordIndex).
- imemData, output, 32: assembled instruction word.
- coreReset, output, 1: active-low reset to the datapath; low except in DONE.
- busy, output, 1: high in LEN_LO, LEN_HI, DATA (and CHK when compiled in).
- done, output, 1: high in DONE.
- error, output, 1: high in ERROR.
- wordCount, output, 16: words written so far in the current load.

Behaviour:
- A byte is accepted on a rising edge where byteValid && byteReady.
- byteReady = 1 in LEN_LO, LEN_HI, DATA, CHK; 0 elsewhere.
- Reset (reset == 0 at an edge):
  - state = IDLE.
  - byteReady, imemWrite, busy, done, error = 0; coreReset = 0.
  - imemAddress = ADDR_BASE; imemData, wordCount, length, byteIndex = 0.
- Reset mid-load aborts the load. Already-written memory words are left as-is; nothing is cleaned up.
- IDLE: start -> LEN_LO.
- LEN_LO: accepted byte -> length[7:0]; go to LEN_HI.
- LEN_HI: accepted byte -> length[15:8]. Then:
  - length == 0 -> DONE.
  - length > MAX_WORDS -> ERROR.
  - otherwise -> DATA.
- DATA:
  - Bytes are placed little-endian into a shift buffer: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24]. byteIndex (2 bits) wraps 3 -> 0.
  - On the edge accepting the 4th byte, imemData is loaded with the full word and imemAddress with ADDR_BASE + 4*wordCount.
  - imemWrite is high for exactly the following cycle (latency 1 from the 4th-byte acceptance).
  - wordCount increments in that same edge.
  - When the incremented wordCount equals length -> DONE (or CHK when compiled in).
  - byteReady stays high during the write cycle, so back-to-back bytes sustain 1 byte/cycle.
- DONE: coreReset = 1 and done = 1. start -> LEN_LO, which clears wordCount and byteIndex; coreReset returns to 0 on that edge.
- ERROR: coreReset = 0 and error = 1. start -> LEN_LO with counters cleared.
- start in LEN_LO / LEN_HI / DATA / CHK is ignored.
- A byteValid pulse with byteReady low is not consumed and has no effect.
- imemAddress arithmetic is 32-bit and wraps modulo 2^32; wordCount is 16-bit and cannot overflow because MAX_WORDS <= 65535.
- At most one imemWrite per 4 accepted bytes; imemWrite is never asserted outside the cycle after a DATA word completes.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all LEN and DATA bytes is kept (cleared when entering LEN_LO).
  - After the last word, state CHK accepts one byte.
  - Byte equal to the running XOR -> DONE; otherwise -> ERROR.
  - length == 0 also passes through CHK.
- Not defined:
  - No CHK state and no checksum register.
  - The last word (or length == 0) goes directly to DONE.

Test Plan:
- Reset / start: reset=0 for 2 cycles, then reset=1 -> coreReset=0, done=0, byteReady=0. Then start=1 for 1 cycle -> byteReady=1, busy=1.
- Two-word load, continuous stream: bytes 02 00 13 05 10 00 93 05 20 00 with byteValid held high. Required response:
  - imemWrite pulse with address 0x0, data 0x00100513;
  - imemWrite pulse with address 0x4, data 0x00200593;
  - then done=1, coreReset=1, wordCount=2.
- Stalled handshake: same image with byteValid toggling 1/0 every cycle -> identical writes and data; each imemWrite is exactly one cycle; no extra writes.
- Oversize image: length bytes 01 01 (257) with MAX_WORDS=256 -> error=1, coreReset=0, no imemWrite. A following start returns to LEN_LO with wordCount=0.
- Reset mid-load: reset=0 after 6 data bytes -> the next edge gives IDLE, busy=0, wordCount=0, imemWrite=0. Exactly one prior write to address 0x0 occurred.
- Checksum (PROGRAM_LOADER_CHECKSUM_EN defined): stream 01 00 13 05 10 00 then checksum 07 -> done=1. Repeating with checksum 08 -> error=1, coreReset=0.
